// File: rtl/alu_issue_if.sv
// Issue-stage handshake bundle: upstream decode inputs and downstream ALU/EX outputs.
// ALU_ISSUE_PERF_CNT_EN adds the issue/stall counter outputs.
interface alu_issue_if #(parameter int WORD_SIZE = 32);
    logic                 i_Valid;
    logic                 o_Ready;
    logic [WORD_SIZE-1:0] i_Instr;
    logic [WORD_SIZE-1:0] i_PC;
    logic [WORD_SIZE-1:0] i_RS1Data;
    logic [WORD_SIZE-1:0] i_RS2Data;
    logic                 o_Valid;
    logic                 i_Ready;
    logic [3:0]           o_Operation;
    logic [WORD_SIZE-1:0] o_Op1;
    logic [WORD_SIZE-1:0] o_Op2;
    logic [WORD_SIZE-1:0] o_StoreData;
    logic [4:0]           o_Rd;
    logic                 o_RegWrite;
    logic                 o_IsBranch;
    logic [2:0]           o_BrFunct3;
    logic                 o_Illegal;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0]          o_IssueCount;
    logic [31:0]          o_StallCount;
`endif

    modport master (
        input  i_Valid, i_Instr, i_PC, i_RS1Data, i_RS2Data, i_Ready,
        output o_Ready, o_Valid, o_Operation, o_Op1, o_Op2, o_StoreData,
        output o_Rd, o_RegWrite, o_IsBranch, o_BrFunct3, o_Illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
        , output o_IssueCount, o_StallCount
`endif
    );

    modport slave (
        output i_Valid, i_Instr, i_PC, i_RS1Data, i_RS2Data, i_Ready,
        input  o_Ready, o_Valid, o_Operation, o_Op1, o_Op2, o_StoreData,
        input  o_Rd, o_RegWrite, o_IsBranch, o_BrFunct3, o_Illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
        , input o_IssueCount, o_StallCount
`endif
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: registered output with a one-entry skid register.
// ALU_ISSUE_PERF_CNT_EN adds free-running issue and stall counters.
//
// state | meaning
// EMPTY | no entry held, ready
// FULL  | output register valid, ready
// SKID  | output and skid registers valid, not ready
module alu_issue #(
    parameter int WORD_SIZE = 32
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Flush,
    alu_issue_if.master bus
);
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;
    localparam logic [3:0] ALU_AUIPC = 4'd11;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic [3:0]           op;
        logic [WORD_SIZE-1:0] op1;
        logic [WORD_SIZE-1:0] op2;
        logic [WORD_SIZE-1:0] store_data;
        logic [4:0]           rd;
        logic                 reg_write;
        logic                 is_branch;
        logic [2:0]           br_funct3;
        logic                 illegal;
    } issue_t;

    state_t state_q, state_d;
    logic   ready_q, valid_q;
    issue_t dec, out_q, skid_q;
    logic   load_out, load_skid, out_from_skid;
    logic   accept, out_xfer;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_field;
    logic [31:0] imm_i, imm_s, imm_j, imm_u;

    assign opcode   = bus.i_Instr[6:0];
    assign funct3   = bus.i_Instr[14:12];
    assign rd_field = bus.i_Instr[11:7];
    assign imm_i    = {{20{bus.i_Instr[31]}}, bus.i_Instr[31:20]};
    assign imm_s    = {{20{bus.i_Instr[31]}}, bus.i_Instr[31:25], bus.i_Instr[11:7]};
    assign imm_j    = {{12{bus.i_Instr[31]}}, bus.i_Instr[19:12], bus.i_Instr[20],
                       bus.i_Instr[30:21], 1'b0};
    assign imm_u    = {12'b0, bus.i_Instr[31:12]};

    // SUB exists only in register-register form; funct7[5] on ADDI is ignored.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic is_imm);
        case (f3)
            3'b000:  arith_op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec    = '0;
        dec.op = ALU_ADD;
        case (opcode)
            7'b0110011: begin
                dec.op        = arith_op(funct3, bus.i_Instr[30], 1'b0);
                dec.op1       = bus.i_RS1Data;
                dec.op2       = bus.i_RS2Data;
                dec.reg_write = 1'b1;
            end
            7'b0010011: begin
                dec.op        = arith_op(funct3, bus.i_Instr[30], 1'b1);
                dec.op1       = bus.i_RS1Data;
                dec.op2       = (funct3 == 3'b001 || funct3 == 3'b101) ?
                                {27'b0, bus.i_Instr[24:20]} : imm_i;
                dec.reg_write = 1'b1;
            end
            7'b0110111: begin
                dec.op        = ALU_LUI;
                dec.op2       = imm_u;
                dec.reg_write = 1'b1;
            end
            7'b0010111: begin
                dec.op        = ALU_AUIPC;
                dec.op1       = bus.i_PC;
                dec.op2       = imm_u;
                dec.reg_write = 1'b1;
            end
            7'b0000011, 7'b1100111: begin
                dec.op1       = bus.i_RS1Data;
                dec.op2       = imm_i;
                dec.reg_write = 1'b1;
            end
            7'b0100011: begin
                dec.op1        = bus.i_RS1Data;
                dec.op2        = imm_s;
                dec.store_data = bus.i_RS2Data;
            end
            7'b1100011: begin
                if (funct3[2:1] == 2'b01) begin
                    dec.illegal = 1'b1;
                end else begin
                    dec.op        = (funct3[2:1] == 2'b00) ? ALU_SUB :
                                    (funct3[1] ? ALU_SLTU : ALU_SLT);
                    dec.op1       = bus.i_RS1Data;
                    dec.op2       = bus.i_RS2Data;
                    dec.is_branch = 1'b1;
                    dec.br_funct3 = funct3;
                end
            end
            7'b1101111: begin
                dec.op1       = bus.i_PC;
                dec.op2       = imm_j;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // x0 is never a real destination, and rd is zeroed whenever nothing is written.
        dec.reg_write = dec.reg_write && (rd_field != 5'd0);
        dec.rd        = dec.reg_write ? rd_field : 5'd0;
    end

    assign accept   = bus.i_Valid && ready_q;
    assign out_xfer = valid_q && bus.i_Ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (i_Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    load_out = 1'b1;
                    state_d  = FULL;
                end
                FULL: begin
                    if (out_xfer && accept) begin
                        load_out = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = SKID;
                    end
                end
                SKID: if (out_xfer) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_d       = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID);
            valid_q <= (state_d != EMPTY);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)  out_q  <= out_from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign bus.o_Ready     = ready_q;
    assign bus.o_Valid     = valid_q;
    assign bus.o_Operation = out_q.op;
    assign bus.o_Op1       = out_q.op1;
    assign bus.o_Op2       = out_q.op2;
    assign bus.o_StoreData = out_q.store_data;
    assign bus.o_Rd        = out_q.rd;
    assign bus.o_RegWrite  = out_q.reg_write;
    assign bus.o_IsBranch  = out_q.is_branch;
    assign bus.o_BrFunct3  = out_q.br_funct3;
    assign bus.o_Illegal   = out_q.illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    // Counters deliberately ignore i_Flush so they survive pipeline redirects.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_xfer)                  issue_cnt_q <= issue_cnt_q + 32'd1;
            if (valid_q && !bus.i_Ready)   stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.o_IssueCount = issue_cnt_q;
    assign bus.o_StallCount = stall_cnt_q;
`else
    // Counter outputs are absent in this build; issue behaviour is unchanged.
`endif
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that drives the execute ALU.
- Converts a decoded-stage RV32I instruction plus register-file read data into the ALU operation code and the two ALU operands, together with sideband fields: rd, write-enable, branch info.
- Registered, valid/ready handshaked, with a 2-entry skid buffer so the pipeline sustains one instruction per cycle under backpressure.
- Outputs feed the ALU operation/operand inputs and the EX pipeline register.

Parameters:
- WORD_SIZE, 32, datapath width; only 32 is supported.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  reset; asynchronous, active-high.
- i_Flush  in  1  discard all buffered entries.
- i_Valid  in  1  upstream instruction valid.
- o_Ready  out  1  stage can accept an instruction.
- i_Instr  in  32  instruction word.
- i_PC  in  32  instruction address.
- i_RS1Data  in  32  rs1 read data.
- i_RS2Data  in  32  rs2 read data.
- o_Valid  out  1  issued entry valid.
- i_Ready  in  1  downstream accepts.
- o_Operation  out  4  ALU operation code (shared ALU_* defines).
- o_Op1  out  32  ALU operand 1.
- o_Op2  out  32  ALU operand 2.
- o_StoreData  out  32  rs2 data for stores.
- o_Rd  out  5  destination register.
- o_RegWrite  out  1  writes rd.
- o_IsBranch  out  1  conditional branch.
- o_BrFunct3  out  3  branch funct3.
- o_Illegal  out  1  unsupported opcode.

Behaviour:
- Reset: state EMPTY; o_Valid=0; o_Ready=1; all data outputs 0.
- Handshake: input transfer when i_Valid&&o_Ready; output transfer when o_Valid&&i_Ready. Outputs are stable while o_Valid&&!i_Ready. Latency is 1 cycle from accept to o_Valid.
- o_Ready is registered: 1 in EMPTY and FULL, 0 in SKID.
- States:
  - EMPTY: on accept, load the output register and go to FULL.
  - FULL, output transfer with accept: reload the output register, stay FULL.
  - FULL, output transfer without accept: go to EMPTY.
  - FULL, no output transfer, with accept: write the skid register, go to SKID.
  - SKID, output transfer: move skid to output, go to FULL.
- i_Flush has priority over everything. Next edge: state EMPTY, o_Valid=0, o_Ready=1. An input presented in the flush cycle is dropped.
- Asynchronous reset mid-transfer: all entries lost, reset values apply immediately.
- Decode (opcode = i_Instr[6:0]). Immediates are sign-extended to 32 bits:
  - OP 0110011: op1=rs1, op2=rs2. funct3/funct7[5] select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. RegWrite=1.
  - OP-IMM 0010011: op1=rs1, op2=I-imm. Shifts use {27'b0,shamt}. funct3=101 with funct7[5]=1 selects SRA. funct7 is ignored for ADDI. RegWrite=1.
  - LUI 0110111: op=LUI, op2={12'b0,i_Instr[31:12]}. RegWrite=1.
  - AUIPC 0010111: op=AUIPC, op1=PC, op2={12'b0,i_Instr[31:12]}. RegWrite=1.
  - LOAD 0000011: ADD rs1+I-imm. RegWrite=1.
  - STORE 0100011: ADD rs1+S-imm, StoreData=rs2. RegWrite=0.
  - BRANCH 1100011: IsBranch=1, BrFunct3=funct3, op1=rs1, op2=rs2. BEQ/BNE use SUB (ALU zero flag); BLT/BGE use SLT; BLTU/BGEU use SLTU. funct3 010/011 is illegal. RegWrite=0.
  - JAL 1101111: ADD PC+J-imm. JALR 1100111: ADD rs1+I-imm. Both RegWrite=1.
  - Any other opcode: o_Illegal=1, op=ADD, op1=op2=0, RegWrite=0, IsBranch=0.
- o_Rd = i_Instr[11:7], forced to 0 when RegWrite=0. RegWrite is also forced 0 when rd=0.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- Defined: adds two ports. o_IssueCount (out, 32) counts output transfers. o_StallCount (out, 32) counts cycles with o_Valid&&!i_Ready.
  - Both counters clear on i_Rst, are unaffected by i_Flush, and wrap modulo 2^32.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then ADD x3,x1,x2 (32'h002081B3) with rs1=5, rs2=7, i_Ready=1 -> next cycle o_Valid=1, o_Operation=ALU_ADD, Op1=5, Op2=7, Rd=3, RegWrite=1.
- SRAI x1,x2,4 (32'h40415093) -> ALU_SRA, Op2=4. ADDI x1,x0,-1 (32'hFFF00093) -> ALU_ADD, Op2=32'hFFFFFFFF.
- AUIPC x5,0x12345 (32'h12345297), PC=32'h100 -> ALU_AUIPC, Op1=32'h100, Op2=32'h00012345.
- Hold i_Ready=0 and send 3 back-to-back instructions -> first two are accepted, o_Ready drops after the second, third is held upstream. Raise i_Ready -> all three emerge in order, none lost or duplicated.
- BLTU (funct3=110) -> ALU_SLTU, IsBranch=1, BrFunct3=3'b110, RegWrite=0. Opcode 7'b1111111 -> o_Illegal=1, Op1=Op2=0.
- SKID state with i_Flush=1 -> next cycle o_Valid=0, o_Ready=1. Assert i_Rst while o_Valid=1 -> o_Valid=0 immediately.
